divider_controller: RTL and testbench
=====================================

Name: divider_controller

Overview:
Request/response front end that sits directly upstream of sequential_divider. It accepts a dividend/divider pair on a valid/ready handshake, issues a one-cycle start pulse to the divider, and holds the operands stable for the whole operation. After the divider's fixed latency it captures the 8-bit quotient and presents it on a valid/ready response port. A zero divider bypasses the divider and returns a saturated result with a flag.

Parameters:
DIV_LATENCY, 11, cycles from the div_en pulse cycle (cycle t) to the cycle in which div_quotient holds the new result (cycle t+11).

Ports:
clk  input  1  system clock, rising edge
nRst  input  1  asynchronous active-low reset
req_valid  input  1  request operands valid
req_ready  output  1  controller can accept a request
req_dividend  input  16  dividend operand
req_divider  input  16  divider operand
resp_valid  output  1  result valid
resp_ready  input  1  consumer accepts result
resp_quotient  output  8  result quotient
resp_dz  output  1  result came from a divide-by-zero bypass
div_en  output  1  start pulse to sequential_divider
div_dividend  output  16  dividend held to sequential_divider
div_divider  output  16  divider held to sequential_divider
div_quotient  input  8  quotient register of sequential_divider
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (nRst low, asynchronous): state=IDLE; op/result registers=0; div_en=0; div_dividend=0; div_divider=0; resp_valid=0; resp_quotient=0; resp_dz=0; busy=0; wait counter=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1 (combinational from state only).
  - Accept happens when req_valid&&req_ready; latch both operands.
  - On accept with req_divider==0: go to RESP, resp_quotient=8'hFF, resp_dz=1, div_en never asserted.
  - On accept with req_divider!=0: go to ISSUE, resp_dz=0.
- ISSUE:
  - Exactly one cycle; div_en=1 in this cycle only.
  - Wait counter cleared to 0; go to WAIT.
- WAIT:
  - Counter increments each cycle, starting at 1 in the first WAIT cycle.
  - When counter==DIV_LATENCY: capture div_quotient into resp_quotient and go to RESP.
  - With the default, capture occurs at cycle t+11 and resp_valid rises at t+12.
  - Counter width is 4 bits, sufficient for DIV_LATENCY<=15; no wrap occurs in legal operation.
- RESP:
  - resp_valid=1; resp_quotient and resp_dz held stable until the handshake.
  - On resp_valid&&resp_ready: go to IDLE and drop resp_valid next cycle.
- Operand hold: div_dividend and div_divider are driven from the latched operand registers in all states. Their values change only on accept, so they are stable through the divider's load cycle (t+1).
- req_ready=0 in ISSUE/WAIT/RESP. Requests are never overlapped and are never dropped while valid stays high.
- Sequence: response handshake cycle -> IDLE next cycle -> earliest new accept. Minimum non-zero op period is 14 cycles with resp_ready tied high.
- div_en is never asserted while the divider is mid-operation. The divider reaches its done state by t+10 and accepts the next pulse from done.
- Reset mid-operation: all state aborts immediately and no response is emitted. The divider shares nRst and restarts from its idle state.
- Simultaneous events: req_valid in RESP is ignored until IDLE. resp_ready outside RESP has no effect.

Test Plan:
- Reset: nRst low mid-run, then release -> all outputs 0; req_ready=1 on the first cycle after release.
- Normal op: accept dividend=16'h0100, divider=16'h0200 at cycle 0. Bench stub drives div_quotient=8'h80 from t+11. Required: div_en=1 only at cycle 1, resp_valid=1 at cycle 13, resp_quotient=8'h80, resp_dz=0.
- Divide-by-zero: dividend=16'h1234, divider=0 -> resp_valid next cycle, resp_quotient=8'hFF, resp_dz=1, div_en stays 0.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_quotient stable, req_ready=0, busy=1. Raise resp_ready -> IDLE the following cycle.
- Back-to-back: two requests with resp_ready=1 -> second div_en exactly 14 cycles after the first; div_divider never changes between accept and response.
- Reset during WAIT (counter=5) -> resp_valid never asserts; next request completes normally with full latency.

Source files
------------

// File: rtl/divider_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : divider_controller_if
// Description : Request/response handshake bundle for divider_controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface divider_controller_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_dividend;
    logic [15:0] req_divider;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_quotient;
    logic        resp_dz;

    // Controller side
    modport slave (
        input  req_valid, req_dividend, req_divider, resp_ready,
        output req_ready, resp_valid, resp_quotient, resp_dz
    );

    // Requester side
    modport master (
        output req_valid, req_dividend, req_divider, resp_ready,
        input  req_ready, resp_valid, resp_quotient, resp_dz
    );
endinterface
`default_nettype wire

// File: rtl/divider_controller.sv
`default_nettype none
// ============================================================================
// Module      : divider_controller
// Description : Valid/ready front end for sequential_divider with a
//               divide-by-zero bypass that returns a saturated quotient.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_controller #(
    parameter int DIV_LATENCY = 11
) (
    input  logic                 clk,
    input  logic                 nRst,
    divider_controller_if.slave  bus,
    output logic                 div_en,
    output logic [15:0]          div_dividend,
    output logic [15:0]          div_divider,
    input  logic [7:0]           div_quotient,
    output logic                 busy
);

    localparam logic [3:0] c_LATENCY = 4'(DIV_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_dividend;
    logic [15:0] r_divider;
    logic [7:0]  r_quotient;
    logic        r_dz;
    logic [3:0]  r_cnt;

    logic w_accept;
    logic w_zero;
    logic w_capture;

    assign w_accept  = bus.req_valid && (r_state == S_IDLE);
    assign w_zero    = (bus.req_divider == 16'd0);
    assign w_capture = (r_state == S_WAIT) && (r_cnt == c_LATENCY);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_zero ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                if (w_capture) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_dividend <= 16'd0;
            r_divider  <= 16'd0;
            r_quotient <= 8'd0;
            r_dz       <= 1'b0;
            r_cnt      <= 4'd0;
        end else begin
            if (w_accept) begin
                r_dividend <= bus.req_dividend;
                r_divider  <= bus.req_divider;
                r_cnt      <= 4'd0;
                r_dz       <= w_zero;
                if (w_zero) begin
                    r_quotient <= 8'hFF;
                end
            end
            // The first WAIT cycle is cycle t+1, so the counter reads 1 there
            // and reaches DIV_LATENCY exactly when the divider result is valid.
            if (r_state == S_ISSUE) begin
                r_cnt <= 4'd1;
            end else if ((r_state == S_WAIT) && !w_capture) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_capture) begin
                r_quotient <= div_quotient;
            end
        end
    end

    assign bus.req_ready     = (r_state == S_IDLE);
    assign bus.resp_valid    = (r_state == S_RESP);
    assign bus.resp_quotient = r_quotient;
    assign bus.resp_dz       = r_dz;

    assign div_en       = (r_state == S_ISSUE);
    assign div_dividend = r_dividend;
    assign div_divider  = r_divider;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_divider_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_controller
// Description : Self-checking bench for divider_controller with a divider stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_controller;

    logic        clk  = 1'b0;
    logic        nRst = 1'b0;
    logic        div_en;
    logic [15:0] div_dividend;
    logic [15:0] div_divider;
    logic [7:0]  div_quotient;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    divider_controller_if bus ();

    divider_controller #(.DIV_LATENCY(11)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .bus          (bus),
        .div_en       (div_en),
        .div_dividend (div_dividend),
        .div_divider  (div_divider),
        .div_quotient (div_quotient),
        .busy         (busy)
    );

    // Divider stub: result appears 11 cycles after the start pulse, junk before.
    logic [7:0] stub_q;
    logic [7:0] stub_pend;
    int         stub_cd;

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            stub_cd      <= 0;
            stub_pend    <= 8'h00;
            div_quotient <= 8'h00;
        end else if (div_en) begin
            stub_cd      <= 10;
            stub_pend    <= stub_q;
            div_quotient <= ~stub_q;
        end else if (stub_cd > 1) begin
            stub_cd <= stub_cd - 1;
        end else if (stub_cd == 1) begin
            stub_cd      <= 0;
            div_quotient <= stub_pend;
        end
    end

    typedef struct {
        logic [15:0] dd;
        logic [15:0] dv;
        logic [7:0]  sq;
        int          stall;
        logic [7:0]  eq;
        logic        edz;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: zero divider saturates with flag, otherwise truncated quotient.
    function automatic logic [8:0] model(input logic [15:0] dd, input logic [15:0] dv);
        logic [15:0] q;
        if (dv == 16'd0) return {1'b1, 8'hFF};
        q = dd / dv;
        return {1'b0, q[7:0]};
    endfunction

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " resp_valid"},    32'(bus.resp_valid),    32'd0);
        chk({nm, " resp_quotient"}, 32'(bus.resp_quotient), 32'd0);
        chk({nm, " resp_dz"},       32'(bus.resp_dz),       32'd0);
        chk({nm, " div_en"},        32'(div_en),            32'd0);
        chk({nm, " div_operands"},  {div_dividend, div_divider}, 32'd0);
        chk({nm, " busy"},          32'(busy),              32'd0);
    endtask

    // One transaction starting from IDLE; returns back in IDLE.
    task automatic do_txn(input string nm, input logic [15:0] dd, input logic [15:0] dv,
                          input logic [7:0] sq, input int stall,
                          input logic [7:0] eq, input logic edz);
        int c;
        int en_cnt;
        int en_cyc;
        int resp_cyc;
        int hold_err;
        int stall_err;
        logic [7:0] q0;
        stub_q           = sq;
        bus.req_valid    = 1'b1;
        bus.req_dividend = dd;
        bus.req_divider  = dv;
        bus.resp_ready   = 1'b0;
        chk({nm, " req_ready_idle"}, 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        c = 1; en_cnt = 0; en_cyc = -1; resp_cyc = -1; hold_err = 0;
        while (c < 40) begin
            if (div_en) begin en_cnt++; en_cyc = c; end
            if (div_dividend !== dd || div_divider !== dv) hold_err++;
            if (bus.resp_valid) begin resp_cyc = c; break; end
            bus.req_dividend = 16'($urandom);
            bus.req_divider  = 16'($urandom);
            bus.resp_ready   = (c + 1 < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            c++;
        end
        bus.resp_ready = 1'b0;
        chk({nm, " resp_latency"}, 32'(resp_cyc), edz ? 32'd1 : 32'd13);
        chk({nm, " div_en_count"}, 32'(en_cnt),   edz ? 32'd0 : 32'd1);
        chk({nm, " div_en_cycle"}, 32'(en_cyc),   edz ? 32'hFFFF_FFFF : 32'd1);
        chk({nm, " resp_quotient"}, 32'(bus.resp_quotient), 32'(eq));
        chk({nm, " resp_dz"},       32'(bus.resp_dz),       32'(edz));
        chk({nm, " busy_resp"},     32'({busy, bus.req_ready}), 32'b10);
        q0 = bus.resp_quotient;
        stall_err = 0;
        for (int s = 0; s < stall; s++) begin
            bus.req_valid    = 1'b1;
            bus.req_dividend = 16'($urandom);
            bus.req_divider  = 16'($urandom);
            step();
            if (bus.resp_valid !== 1'b1 || bus.resp_quotient !== q0 || bus.resp_dz !== edz ||
                bus.req_ready !== 1'b0 || busy !== 1'b1 || div_divider !== dv || div_dividend !== dd)
                stall_err++;
        end
        chk({nm, " operand_hold"}, 32'(hold_err), 32'd0);
        chk({nm, " backpressure"}, 32'(stall_err), 32'd0);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        chk({nm, " after_handshake"}, 32'({bus.resp_valid, bus.req_ready, busy}), 32'b010);
    endtask

    initial begin
        logic [8:0]  m;
        logic [15:0] rdd;
        logic [15:0] rdv;
        int          err;
        int          en_q[$];
        int          rv_q[$];
        logic [7:0]  rq_q[$];

        vecs[0] = '{16'h0100, 16'h0200, 8'h80, 0, 8'h80, 1'b0};
        vecs[1] = '{16'h1234, 16'h0000, 8'h00, 0, 8'hFF, 1'b1};
        vecs[2] = '{16'h0064, 16'h0007, 8'h0E, 5, 8'h0E, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0001, 8'hFF, 1, 8'hFF, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 8'h00, 2, 8'hFF, 1'b1};
        vecs[5] = '{16'h0050, 16'h0003, 8'h1A, 0, 8'h1A, 1'b0};

        bus.req_valid    = 1'b0;
        bus.req_dividend = 16'd0;
        bus.req_divider  = 16'd0;
        bus.resp_ready   = 1'b0;
        stub_q           = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        nRst = 1'b1;
        step();
        chk("reset req_ready_after_release", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv, vecs[i].sq,
                   vecs[i].stall, vecs[i].eq, vecs[i].edz);
        end

        // Reset while WAIT counter reads 5 (cycle 6 after accept)
        bus.req_valid    = 1'b1;
        bus.req_dividend = 16'h0777;
        bus.req_divider  = 16'h0011;
        stub_q           = 8'h70;
        step();
        bus.req_valid = 1'b0;
        repeat (5) step();
        chk("wait_reset busy_before", 32'(busy), 32'd1);
        nRst = 1'b0;
        #1;
        chk_reset_outputs("wait_reset");
        step();
        step();
        @(negedge clk);
        nRst = 1'b1;
        step();
        chk("wait_reset req_ready_after_release", 32'(bus.req_ready), 32'd1);
        err = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.resp_valid !== 1'b0 || busy !== 1'b0) err++;
            step();
        end
        chk("wait_reset no_response", 32'(err), 32'd0);
        do_txn("after_reset", 16'h0777, 16'h0011, 8'h70, 0, 8'h70, 1'b0);

        // Back-to-back with valid held high and resp_ready tied high
        bus.resp_ready   = 1'b1;
        bus.req_valid    = 1'b1;
        bus.req_dividend = 16'h0400;
        bus.req_divider  = 16'h0010;
        stub_q           = 8'h40;
        step();
        bus.req_dividend = 16'h0900;
        bus.req_divider  = 16'h0030;
        err = 0;
        for (int c = 1; c < 29; c++) begin
            if (div_en) en_q.push_back(c);
            if (bus.resp_valid) begin rv_q.push_back(c); rq_q.push_back(bus.resp_quotient); end
            if ((c <= 14) ? (div_divider !== 16'h0010 || div_dividend !== 16'h0400)
                          : (div_divider !== 16'h0030 || div_dividend !== 16'h0900)) err++;
            if (c == 2)  stub_q = 8'h30;
            if (c == 15) bus.req_valid = 1'b0;
            step();
        end
        chk("b2b div_en_count", 32'(en_q.size()), 32'd2);
        chk("b2b first_div_en", 32'((en_q.size() > 0) ? en_q[0] : -1), 32'd1);
        chk("b2b div_en_spacing", 32'((en_q.size() > 1) ? en_q[1] - en_q[0] : -1), 32'd14);
        chk("b2b resp_cycles", {16'((rv_q.size() > 0) ? rv_q[0] : -1), 16'((rv_q.size() > 1) ? rv_q[1] : -1)},
            {16'd13, 16'd27});
        chk("b2b quotients", {8'((rq_q.size() > 0) ? rq_q[0] : 8'h00), 8'((rq_q.size() > 1) ? rq_q[1] : 8'h00)},
            {8'h40, 8'h30});
        chk("b2b operand_hold", 32'(err), 32'd0);
        chk("b2b idle_after", 32'({busy, bus.req_ready}), 32'b01);
        bus.resp_ready = 1'b0;

        // Randomized transactions against the reference model
        for (int i = 0; i < 24; i++) begin
            rdd = 16'($urandom);
            if ($urandom_range(0, 4) == 0)      rdv = 16'd0;
            else if ($urandom_range(0, 1) == 0) rdv = 16'($urandom_range(1, 15));
            else                                rdv = 16'($urandom_range(1, 65535));
            m = model(rdd, rdv);
            do_txn($sformatf("rand%0d", i), rdd, rdv, m[7:0], $urandom_range(0, 3), m[7:0], m[8]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
